load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/half/word/double loads and stores onto a
// doubleword-wide data memory.
//
// Every memory transfer moves 8 bytes. Loads read the doubleword at the request
// address and extend its low bytes. Double stores write it directly. Narrower
// stores do a read-modify-write that keeps the upper bytes of the doubleword.
//
// Parameters:
//   MEM_SIZE        byte capacity of the attached data memory
// Compile-time option:
//   MISALIGN_TRAP_EN  when defined, an access whose address is not a multiple
//                     of its size is rejected with resp_error
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   req_valid/req_ready               request handshake (ready only in idle)
//   req_write, req_size, req_unsigned access kind, size (00 B, 01 H, 10 W, 11 D),
//                                     and zero- or sign-extension for loads
//   req_address, req_data             byte address, right-aligned store data
//   resp_valid, resp_data, resp_error one-cycle completion with load result
//   mem_address, mem_read, mem_write  memory strobes, active only in READ/WRITE
//   mem_write_data, mem_read_data     8-byte little-endian memory data
module load_store_unit #(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_address,
    input  logic [63:0] req_data,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_error,
    output logic [63:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    // Highest address at which a full 8-byte transfer still fits.
    localparam logic [63:0] LastAddr = 64'(MEM_SIZE) - 64'd8;

    state_e      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [63:0] address_q;
    logic [63:0] data_q;
    logic        error_q;
    logic [63:0] rdata_q;

    logic        accept;
    logic        req_error;
    logic        misalign;
    logic [63:0] merged;
    logic [63:0] load_ext;

    assign accept = req_valid && (state_q == StIdle);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        unique case (req_size)
            2'b00: misalign = 1'b0;
            2'b01: misalign = req_address[0];
            2'b10: misalign = |req_address[1:0];
            2'b11: misalign = |req_address[2:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign req_error = (req_address > LastAddr) || misalign;

    // Request capture and read-data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            address_q  <= 64'd0;
            data_q     <= 64'd0;
            error_q    <= 1'b0;
            rdata_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                address_q  <= req_address;
                data_q     <= req_data;
                error_q    <= req_error;
            end
            if (state_q == StRead) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_error) begin
                        state_d = StResp;
                    end else if (req_write && (req_size == 2'b11)) begin
                        state_d = StWrite;
                    end else begin
                        // Loads and narrow stores both start with a read.
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = write_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Narrow stores overlay their low bytes onto the doubleword read in StRead.
    always_comb begin
        merged = data_q;
        unique case (size_q)
            2'b00: merged = {rdata_q[63:8], data_q[7:0]};
            2'b01: merged = {rdata_q[63:16], data_q[15:0]};
            2'b10: merged = {rdata_q[63:32], data_q[31:0]};
            2'b11: merged = data_q;
            default: merged = data_q;
        endcase
    end

    always_comb begin
        load_ext = rdata_q;
        unique case (size_q)
            2'b00: load_ext = unsigned_q ? {56'd0, rdata_q[7:0]}
                                         : {{56{rdata_q[7]}}, rdata_q[7:0]};
            2'b01: load_ext = unsigned_q ? {48'd0, rdata_q[15:0]}
                                         : {{48{rdata_q[15]}}, rdata_q[15:0]};
            2'b10: load_ext = unsigned_q ? {32'd0, rdata_q[31:0]}
                                         : {{32{rdata_q[31]}}, rdata_q[31:0]};
            2'b11: load_ext = rdata_q;
            default: load_ext = rdata_q;
        endcase
    end

    // Outputs decoded from state so that reset clears them immediately.
    always_comb begin
        req_ready      = (state_q == StIdle);
        mem_read       = (state_q == StRead);
        mem_write      = (state_q == StWrite);
        mem_address    = 64'd0;
        mem_write_data = 64'd0;
        resp_valid     = (state_q == StResp);
        resp_error     = 1'b0;
        resp_data      = 64'd0;
        if ((state_q == StRead) || (state_q == StWrite)) begin
            mem_address = address_q;
        end
        if (state_q == StWrite) begin
            mem_write_data = merged;
        end
        if (state_q == StResp) begin
            resp_error = error_q;
            if (!write_q && !error_q) begin
                resp_data = load_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-byte behavioural memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_address = 64'd0;
    logic [63:0] req_data = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_error;
    logic [63:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] mem [0:255];
    logic       mem_fill = 1'b1;
    int         rd_cycles = 0;
    int         wr_cycles = 0;
    int         both_cycles = 0;

    load_store_unit #(.MEM_SIZE(256)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_address(req_address),
        .req_data(req_data),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_error(resp_error),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    // Combinational little-endian read of 8 bytes.
    always_comb begin
        mem_read_data = 64'd0;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] a;
            a = mem_address + 64'(i);
            if (a < 64'd256) mem_read_data[8*i +: 8] = mem[a[7:0]];
        end
    end

    always @(posedge clock) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h07;
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++) begin
                logic [63:0] a;
                a = mem_address + 64'(i);
                if (a < 64'd256) mem[a[7:0]] <= mem_write_data[8*i +: 8];
            end
        end
        if (mem_read) rd_cycles <= rd_cycles + 1;
        if (mem_write) wr_cycles <= wr_cycles + 1;
        if (mem_read && mem_write) both_cycles <= both_cycles + 1;
    end

    // Drives one request, waits (bounded) for resp_valid and reports what was seen.
    // lat counts clock edges from the acceptance edge to the response cycle.
    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] data,
                         output int lat, output logic [63:0] rdata, output logic err,
                         output int rds, output int wrs, output logic ready_in_resp);
        int rd0, wr0;
        @(negedge clock);
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_address  = addr;
        req_data     = data;
        @(posedge clock);
        #1;
        // Scramble the request to show captured fields are used afterwards.
        req_valid    = 1'b0;
        req_write    = ~wr;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_address  = 64'hF9;
        req_data     = ~data;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
        rdata = resp_data;
        err = resp_error;
        ready_in_resp = req_ready;
        @(negedge clock);
        rds = rd_cycles - rd0;
        wrs = wr_cycles - wr0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        n_checks++;
        if ({resp_valid, resp_error, mem_read, mem_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {resp_valid, resp_error, mem_read, mem_write});
        end
        n_checks++;
        if ({resp_data, mem_address, mem_write_data} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h want 0", resp_data, mem_address,
                     mem_write_data);
        end
        @(negedge clock);
        mem_fill = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_load_double();
        int lat, rds, wrs; logic [63:0] d; logic e, rdy;
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL ld_d_latency: got %0d want 2", lat); end
        n_checks++;
        if (d !== 64'h0707070707070707 || e !== 1'b0) begin
            n_fail++; $display("FAIL ld_d_data: got %h err %b want 0707070707070707 err 0", d, e);
        end
        n_checks++;
        if (rds !== 1 || wrs !== 0) begin
            n_fail++; $display("FAIL ld_d_cycles: got rd %0d wr %0d want rd 1 wr 0", rds, wrs);
        end
        n_checks++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL ready_in_resp: got %b want 0", rdy); end
    endtask

    task automatic test_store_half();
        int lat, rds, wrs; logic [63:0] d; logic e, rdy;
        issue(1'b1, 2'b01, 1'b0, 64'h20, 64'h123456789ABCBEEF, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL st_h_latency: got %0d want 3", lat); end
        n_checks++;
        if (rds !== 1 || wrs !== 1) begin
            n_fail++; $display("FAIL st_h_cycles: got rd %0d wr %0d want rd 1 wr 1", rds, wrs);
        end
        n_checks++;
        if (d !== 64'd0 || e !== 1'b0) begin
            n_fail++; $display("FAIL st_h_resp: got %h err %b want 0 err 0", d, e);
        end
        issue(1'b0, 2'b11, 1'b0, 64'h20, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'h070707070707BEEF) begin
            n_fail++; $display("FAIL st_h_readback: got %h want 070707070707beef", d);
        end
        issue(1'b0, 2'b01, 1'b0, 64'h20, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'hFFFFFFFFFFFFBEEF) begin
            n_fail++; $display("FAIL ld_h_signed: got %h want ffffffffffffbeef", d);
        end
        issue(1'b0, 2'b01, 1'b1, 64'h20, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'h000000000000BEEF) begin
            n_fail++; $display("FAIL ld_h_unsigned: got %h want 000000000000beef", d);
        end
    endtask

    task automatic test_store_byte();
        int lat, rds, wrs; logic [63:0] d; logic e, rdy;
        issue(1'b1, 2'b00, 1'b0, 64'h30, 64'hFFFFFFFFFFFFFF80, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (lat !== 3 || rds !== 1 || wrs !== 1) begin
            n_fail++;
            $display("FAIL st_b_timing: got lat %0d rd %0d wr %0d want 3 1 1", lat, rds, wrs);
        end
        issue(1'b0, 2'b00, 1'b0, 64'h30, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'hFFFFFFFFFFFFFF80) begin
            n_fail++; $display("FAIL ld_b_signed: got %h want ffffffffffffff80", d);
        end
        issue(1'b0, 2'b00, 1'b1, 64'h30, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'h0000000000000080) begin
            n_fail++; $display("FAIL ld_b_unsigned: got %h want 0000000000000080", d);
        end
        issue(1'b0, 2'b10, 1'b0, 64'h30, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'h0000000007070780) begin
            n_fail++; $display("FAIL ld_w_positive: got %h want 0000000007070780", d);
        end
    endtask

    task automatic test_store_double();
        int lat, rds, wrs; logic [63:0] d; logic e, rdy;
        issue(1'b1, 2'b11, 1'b0, 64'h40, 64'h8877665544332211, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (lat !== 2 || rds !== 0 || wrs !== 1) begin
            n_fail++;
            $display("FAIL st_d_timing: got lat %0d rd %0d wr %0d want 2 0 1", lat, rds, wrs);
        end
        issue(1'b0, 2'b11, 1'b0, 64'h40, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'h8877665544332211) begin
            n_fail++; $display("FAIL st_d_readback: got %h want 8877665544332211", d);
        end
        issue(1'b0, 2'b10, 1'b0, 64'h44, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'hFFFFFFFF88776655) begin
            n_fail++; $display("FAIL ld_w_signed: got %h want ffffffff88776655", d);
        end
    endtask

    task automatic test_range_error();
        int lat, rds, wrs; logic [63:0] d; logic e, rdy;
        issue(1'b0, 2'b00, 1'b0, 64'hF9, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (lat !== 1 || e !== 1'b1 || d !== 64'd0) begin
            n_fail++;
            $display("FAIL err_load: got lat %0d err %b data %h want 1 1 0", lat, e, d);
        end
        n_checks++;
        if (rds !== 0 || wrs !== 0) begin
            n_fail++; $display("FAIL err_load_mem: got rd %0d wr %0d want 0 0", rds, wrs);
        end
        issue(1'b1, 2'b11, 1'b0, 64'hF9, 64'hDEAD, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (lat !== 1 || e !== 1'b1 || wrs !== 0 || rds !== 0) begin
            n_fail++;
            $display("FAIL err_store: got lat %0d err %b rd %0d wr %0d want 1 1 0 0",
                     lat, e, rds, wrs);
        end
        issue(1'b0, 2'b11, 1'b0, 64'hF8, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (lat !== 2 || e !== 1'b0 || d !== 64'h0707070707070707) begin
            n_fail++;
            $display("FAIL edge_f8: got lat %0d err %b data %h want 2 0 0707070707070707",
                     lat, e, d);
        end
    endtask

    task automatic test_misalign();
        int lat, rds, wrs; logic [63:0] d; logic e, rdy;
        issue(1'b1, 2'b10, 1'b0, 64'h22, 64'h00000000CAFEF00D, lat, d, e, rds, wrs, rdy);
`ifdef MISALIGN_TRAP_EN
        n_checks++;
        if (lat !== 1 || e !== 1'b1 || wrs !== 0 || rds !== 0) begin
            n_fail++;
            $display("FAIL misalign_trap: got lat %0d err %b rd %0d wr %0d want 1 1 0 0",
                     lat, e, rds, wrs);
        end
`else
        n_checks++;
        if (lat !== 3 || e !== 1'b0 || wrs !== 1) begin
            n_fail++;
            $display("FAIL misalign_store: got lat %0d err %b wr %0d want 3 0 1", lat, e, wrs);
        end
        issue(1'b0, 2'b10, 1'b1, 64'h22, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'h00000000CAFEF00D || e !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_load: got %h err %b want 00000000cafef00d err 0", d, e);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int wr0;
        int lat, rds, wrs; logic [63:0] d; logic e, rdy;
        @(negedge clock);
        wr0 = wr_cycles;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_size    = 2'b00;
        req_address = 64'h50;
        req_data    = 64'h55;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1) begin
            n_fail++; $display("FAIL abort_in_read: got mem_read %b want 1", mem_read);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: got ready %b rd %b wr %b want 1 0 0",
                     req_ready, mem_read, mem_write);
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_held: got resp_valid %b ready %b want 0 1", resp_valid,
                     req_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (wr_cycles - wr0 !== 0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_write: got writes %0d resp_valid %b want 0 0",
                     wr_cycles - wr0, resp_valid);
        end
        issue(1'b0, 2'b11, 1'b0, 64'h50, 64'd0, lat, d, e, rds, wrs, rdy);
        n_checks++;
        if (d !== 64'h0707070707070707) begin
            n_fail++; $display("FAIL abort_mem_intact: got %h want 0707070707070707", d);
        end
    endtask

    task automatic test_exclusive_strobes();
        n_checks++;
        if (both_cycles !== 0) begin
            n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", both_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_double();
        test_store_half();
        test_store_byte();
        test_store_double();
        test_range_error();
        test_misalign();
        test_reset_abort();
        test_exclusive_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
